// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the EX-stage multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = 5;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and muldiv_unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        op_valid;
  md_op_t      op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_read;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, rs_data, rt_data, hilo_read, flush,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, hilo_read, flush,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
// Multiply and divide share one 64-bit accumulator and a 5-bit iteration counter.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  md_state_t           state, next_state;
  logic [MD_CNT_W-1:0] cnt;
  logic [63:0]         acc;
  logic [31:0]         opb, rs_raw, hi_reg, lo_reg;
  logic                is_div, neg_res, neg_rem, div_zero;

  logic        iter_op, signed_op, div_op, accept, write_hi, write_lo, sa, sb, busy;
  logic [31:0] a_mag, b_mag, quo, rem, res_hi, res_lo;
  logic [32:0] mul_sum, rem_sh;
  logic        rem_ge;
  logic [63:0] acc_iter, product;

  always_comb begin
    iter_op   = bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    signed_op = bus.op inside {MD_MULT, MD_DIV};
    div_op    = bus.op inside {MD_DIV, MD_DIVU};
    accept    = bus.op_valid & iter_op & (state == MD_IDLE) & ~bus.flush;
    write_hi  = bus.op_valid & (bus.op == MD_MTHI) & (state == MD_IDLE) & ~bus.flush;
    write_lo  = bus.op_valid & (bus.op == MD_MTLO) & (state == MD_IDLE) & ~bus.flush;
    sa        = signed_op & bus.rs_data[31];
    sb        = signed_op & bus.rt_data[31];
    a_mag     = sa ? -bus.rs_data : bus.rs_data;
    b_mag     = sb ? -bus.rt_data : bus.rt_data;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'h0)};
    rem_sh   = acc[63:31];
    rem_ge   = rem_sh >= {1'b0, opb};
    acc_iter = is_div ? {(rem_ge ? 32'(rem_sh - {1'b0, opb}) : rem_sh[31:0]), acc[30:0], rem_ge}
                      : {mul_sum, acc[31:1]};
    product  = neg_res ? -acc : acc;
    quo      = neg_res ? -acc[31:0] : acc[31:0];
    rem      = neg_rem ? -acc[63:32] : acc[63:32];
    res_hi   = div_zero ? rs_raw : (is_div ? rem : product[63:32]);
    res_lo   = div_zero ? '1     : (is_div ? quo : product[31:0]);
  end

  always_comb begin
    next_state = state;
    case (state)
      MD_IDLE: if (accept) next_state = MD_ITER;
      MD_ITER: begin
        if (bus.flush)                                   next_state = MD_IDLE;
        else if (cnt == MD_CNT_W'(MD_ITERS - 1))         next_state = MD_FIX;
      end
      MD_FIX:  next_state = MD_IDLE;
      default: next_state = MD_IDLE;
    endcase
    busy = (state != MD_IDLE);
  end

  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.op_valid | bus.hilo_read);
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      rs_raw   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      if (accept) begin
        acc      <= {32'h0, (div_op ? a_mag : b_mag)};
        opb      <= div_op ? b_mag : a_mag;
        rs_raw   <= bus.rs_data;
        is_div   <= div_op;
        neg_res  <= sa ^ sb;
        neg_rem  <= sa;
        div_zero <= div_op & (bus.rt_data == '0);
        cnt      <= '0;
      end else if (state == MD_ITER) begin
        acc <= acc_iter;
        cnt <= cnt + MD_CNT_W'(1);
      end

      if (state == MD_FIX) begin
        if (!bus.flush) begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
      end else begin
        if (write_hi) hi_reg <= bus.rs_data;
        if (write_lo) lo_reg <= bus.rs_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus corner-case sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    md_op_t      op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs_data  = a;
    bus.rt_data  = b;
    tick();
    bus.op_valid = 1'b0;
    bus.op       = MD_NONE;
  endtask

  // Entered in cycle 1 after the accept edge; leaves the bench in cycle 34.
  task automatic wait_done(input string name);
    int unsigned busy_cycles;
    busy_cycles = 0;
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
    end
    check({name, " busy cycles"}, 64'(busy_cycles), 64'd33);
    check({name, " busy low c34"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic write_reg(input md_op_t o, input logic [31:0] v);
    issue(o, v, 32'h0);
  endtask

  initial begin
    int unsigned stall_cnt;

    vecs[0]  = '{"mult -2x3",      MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu max^2",    MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div -7/2",       MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu 7/0",       MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{"div ovf",        MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"divu 100/7",     MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{"mult 7x-5",      MD_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
    vecs[7]  = '{"div 7/-2",       MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{"div -7/0",       MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"multu x16",      MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{"divu max/1",     MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op        = MD_NONE;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.hilo_read = 1'b1;
    bus.flush     = 1'b0;
    tick();
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    bus.hilo_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(vecs[i].name);
      check({vecs[i].name, " hi"}, 64'(bus.hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, " lo"}, 64'(bus.lo), 64'(vecs[i].exp_lo));
    end

    // MTHI/MTLO: registered, visible the cycle after issue
    bus.op_valid = 1'b1; bus.op = MD_MTHI; bus.rs_data = 32'hDEADBEEF;
    #1;
    check("mthi no comb path", 64'(bus.hi), 64'h0);
    tick();
    bus.op_valid = 1'b0; bus.op = MD_NONE;
    check("mthi value", 64'(bus.hi), 64'hDEADBEEF);
    write_reg(MD_MTLO, 32'hCAFEF00D);
    check("mtlo value", 64'(bus.lo), 64'hCAFEF00D);
    check("mtlo keeps hi", 64'(bus.hi), 64'hDEADBEEF);

    // MFHI waiting behind a DIV, with an independent op in cycle 2
    issue(MD_DIV, 32'd20, 32'd3);
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      bus.hilo_read = (c != 2);
      #1;
      if (c == 2) check("indep no stall", 64'(bus.stall), 64'd0);
      else if (bus.stall === 1'b1) stall_cnt++;
      tick();
    end
    bus.hilo_read = 1'b1;
    #1;
    check("mfhi stall cycles", 64'(stall_cnt), 64'd32);
    check("mfhi stall drop c34", 64'(bus.stall), 64'd0);
    check("mfhi sees hi", 64'(bus.hi), 64'd2);
    check("div 20/3 lo", 64'(bus.lo), 64'd6);
    bus.hilo_read = 1'b0;
    tick();

    // back-to-back: second op held from cycle 1, accepted at end of cycle 34
    issue(MD_MULTU, 32'd3, 32'd5);
    bus.op_valid = 1'b1; bus.op = MD_DIVU; bus.rs_data = 32'd50; bus.rt_data = 32'd6;
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      #1;
      if (bus.stall === 1'b1) stall_cnt++;
      tick();
    end
    #1;
    check("b2b stall cycles", 64'(stall_cnt), 64'd33);
    check("b2b stall low c34", 64'(bus.stall), 64'd0);
    check("b2b first lo", 64'(bus.lo), 64'd15);
    tick();
    bus.op_valid = 1'b0; bus.op = MD_NONE;
    check("b2b second busy", 64'(bus.busy), 64'd1);
    wait_done("b2b second");
    check("b2b second hi", 64'(bus.hi), 64'd2);
    check("b2b second lo", 64'(bus.lo), 64'd8);

    // flush in cycle 10 aborts, flush with MTLO ignores the write
    write_reg(MD_MTHI, 32'h11111111);
    write_reg(MD_MTLO, 32'h22222222);
    issue(MD_DIVU, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush idle", 64'(bus.busy), 64'd0);
    check("flush hi kept", 64'(bus.hi), 64'h11111111);
    check("flush lo kept", 64'(bus.lo), 64'h22222222);
    bus.op_valid = 1'b1; bus.op = MD_MTLO; bus.rs_data = 32'h12345678; bus.flush = 1'b1;
    tick();
    bus.op_valid = 1'b0; bus.op = MD_NONE; bus.flush = 1'b0;
    check("flushed mtlo", 64'(bus.lo), 64'h22222222);
    for (int c = 1; c < 40; c++) tick();
    check("flushed div no late write", 64'(bus.hi), 64'h11111111);

    // flush in FIX suppresses the result write
    issue(MD_DIVU, 32'd100, 32'd7);
    for (int c = 1; c < 33; c++) tick();
    check("fix state busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fix flush busy", 64'(bus.busy), 64'd0);
    check("fix flush hi", 64'(bus.hi), 64'h11111111);
    check("fix flush lo", 64'(bus.lo), 64'h22222222);

    // asynchronous reset in cycle 20 of a MULT
    issue(MD_MULT, 32'd5, 32'd6);
    for (int c = 1; c < 20; c++) tick();
    bus.hilo_read = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst stall", 64'(bus.stall), 64'd0);
    bus.hilo_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    write_reg(MD_MTHI, 32'hA5A5A5A5);
    check("post rst mthi", 64'(bus.hi), 64'hA5A5A5A5);
    for (int c = 0; c < 40; c++) tick();
    check("post rst lo stays", 64'(bus.lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the five-stage MIPS pipeline. It sits directly downstream of the operand forwarding muxes and takes fully forwarded rs/rt values. It executes MULT/MULTU/DIV/DIVU over 32 iteration cycles, or writes MTHI/MTLO in a single cycle. It raises a stall whenever a dependent instruction reaches EX while an operation is in flight.

## Interface
- No parameters; data width is fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1: the instruction in EX is a muldiv-class op.
- `op` in 3: `md_op_t` opcode.
- `rs_data` in 32: forwarded rs operand (dividend / multiplicand / MTHI/MTLO source).
- `rt_data` in 32: forwarded rt operand (divisor / multiplier).
- `hilo_read` in 1: the instruction in EX is MFHI or MFLO.
- `flush` in 1: the EX instruction is squashed and any in-flight operation is aborted.
- `stall` out 1: freezes IF through EX.
- `busy` out 1: an iterative operation is in progress.
- `hi` out 32: registered HI.
- `lo` out 32: registered LO.

## Operation
- States: IDLE, ITER, FIX.
- accept = op_valid & op∈{MULT,MULTU,DIV,DIVU} & state==IDLE & ~flush.
- Write path = op_valid & op∈{MTHI,MTLO} & state==IDLE & ~flush.
  - On the write path, the selected register takes `rs_data` at the edge.
  - The state stays IDLE.
- On accept:
  - Latch |rs| and |rt|. For signed ops use two's-complement magnitudes; for unsigned ops use the raw values.
  - Latch the result sign (sa^sb) and the remainder sign (sa).
  - Set iteration counter = 0, then go to ITER.
- ITER, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
- ITER, divide: restoring division, one quotient bit per cycle, 32 cycles.
- After count 31, go to FIX.
- FIX:
  - Apply sign correction. Multiply: negate the 64-bit product if the sign bit is set. Divide: negate the quotient if sa^sb; negate the remainder if sa.
  - Write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: HI = remainder, LO = quotient.
  - Return to IDLE.
- Divide by zero (rt==0): same latency; HI = rs_data as issued, LO = 0xFFFFFFFF; signed and unsigned alike.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- busy = (state != IDLE).
- stall = busy & (op_valid | hilo_read), combinational. Independent instructions proceed while busy.
- Flush:
  - Has priority over everything else: next state is IDLE, no HI/LO write.
  - An op presented together with flush is ignored.
  - A flush during FIX also suppresses the HI/LO write.
- Reset: state IDLE, counter 0, hi = 0, lo = 0, busy = 0, stall = 0.
  - Reset asserted mid-operation discards the operation.

## Timing
- Accept edge ends cycle 0.
- ITER occupies cycles 1–32; FIX is cycle 33. HI/LO take the result at the end of cycle 33.
- Cycle 34: busy = 0. An MFHI/MFLO held in EX since any earlier cycle sees the new value in cycle 34 and stall drops in that same cycle.
- Back-to-back muldiv ops: the second is stalled until cycle 34, then accepted at the end of cycle 34.
- MTHI/MTLO latency is 1: the value is visible on `hi`/`lo` the cycle after issue.
- `hi`/`lo` are register outputs with no combinational path from inputs; the forwarding logic consumes them as EX result data.

## Structure
- The shared CPU package holds:
  - `md_op_t` enum (3 bits): MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - The state enum for IDLE/ITER/FIX.
  - The constant `MD_ITERS = 32`.
- No sub-module: the multiply and divide datapaths share the 64-bit accumulator and counter inside one module.
- Counter width: 5 bits.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=0x00000003 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high for exactly cycles 1–33.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- MFHI issued in the cycle after a DIV -> stall high in cycles 1–33, low in cycle 34; an independent ALU op with hilo_read=0 in cycle 2 -> stall=0.
- DIVU 100/7 with flush asserted in cycle 10 -> IDLE next cycle, HI/LO keep their prior values. MTLO 0x12345678 issued together with flush -> LO unchanged.
- rst_n pulsed low in cycle 20 of a MULT -> immediately hi=0, lo=0, busy=0; a new MTHI 0xA5A5A5A5 after release -> hi=0xA5A5A5A5 next cycle.
